// File: rtl/frog_lane_sched.sv
// Per-frame motion scheduler for the frog sprite slots: CPU-written position/ctrl/velocity
// registers, swept one slot per clock after each frame tick (x wrap + animation toggle).
module frog_lane_sched #(
    parameter int N_SLOT   = 20,
    parameter int SCR_W    = 640,
    parameter int H_SIZE   = 32,
    parameter int ANIM_DIV = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_tick,
    input  logic                  wr_en,
    input  logic [4:0]            wr_addr,
    input  logic [1:0]            wr_sel,
    input  logic [10:0]           wr_data,
    output logic [N_SLOT*11-1:0]  x_flat,
    output logic [N_SLOT*11-1:0]  y_flat,
    output logic [N_SLOT*4-1:0]   ctrl_flat,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);

    localparam int             SPAN      = SCR_W + H_SIZE;
    localparam logic [11:0]    SPAN12    = 12'(SPAN);
    localparam int             AW        = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [AW-1:0]  ANIM_LAST = AW'(ANIM_DIV - 1);
    localparam logic [4:0]     IDX_LAST  = 5'(N_SLOT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [4:0]      r_idx;
    logic [AW-1:0]   r_anim_cnt;
    logic            r_anim_now;
    logic            r_busy;
    logic            r_done;
    logic            r_overrun;
    logic            w_start;

    logic [10:0]     r_x    [N_SLOT];
    logic [10:0]     r_y    [N_SLOT];
    logic [3:0]      r_ctrl [N_SLOT];
    logic [4:0]      r_vel  [N_SLOT];

    logic [10:0]     w_cur_x;
    logic [4:0]      w_cur_v;
    logic [11:0]     w_x12;
    logic [11:0]     w_sum;
    logic [11:0]     w_mag;
    logic [11:0]     w_new12;
    logic [10:0]     w_upd_x;
    logic            w_move;

    assign w_start = (r_state == IDLE) && frame_tick;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (frame_tick) w_state_next = SCAN;
            SCAN:    if (r_idx == IDX_LAST) w_state_next = FIN;
            FIN:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_anim_cnt <= '0;
            r_anim_now <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != IDLE);
            r_done  <= (w_state_next == FIN);
            // A tick during SCAN or FIN is dropped but remembered until reset.
            if (frame_tick && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end
            if (w_start) begin
                r_idx      <= '0;
                r_anim_now <= (r_anim_cnt == ANIM_LAST);
                r_anim_cnt <= (r_anim_cnt == ANIM_LAST) ? '0 : r_anim_cnt + 1'b1;
            end else if ((r_state == SCAN) && (r_idx != IDX_LAST)) begin
                r_idx <= r_idx + 5'd1;
            end
        end
    end

    // Shared x datapath for the slot under the sweep; 12-bit math avoids 11-bit overflow.
    assign w_cur_x = r_x[r_idx];
    assign w_cur_v = r_vel[r_idx];
    assign w_x12   = {1'b0, w_cur_x};
    assign w_sum   = w_x12 + {7'd0, w_cur_v};
    assign w_mag   = {7'd0, (~w_cur_v) + 5'd1};
    assign w_move  = (w_cur_v != 5'd0);

    always_comb begin
        w_new12 = w_x12;
        if (!w_cur_v[4]) begin
            w_new12 = (w_sum >= SPAN12) ? (w_sum - SPAN12) : w_sum;
        end else begin
            w_new12 = (w_x12 < w_mag) ? (w_x12 + SPAN12 - w_mag) : (w_x12 - w_mag);
        end
        w_upd_x = w_new12[10:0];
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_SLOT; gi++) begin : g_slot
            logic w_hit;
            logic w_wr;

            assign w_hit = (r_state == SCAN) && (r_idx == 5'(gi)) && w_move;
            assign w_wr  = wr_en && (wr_addr == 5'(gi));

            // The CPU write comes last so it overrides the sweep for the same field only.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_x[gi]    <= '0;
                    r_y[gi]    <= '0;
                    r_ctrl[gi] <= '0;
                    r_vel[gi]  <= '0;
                end else begin
                    if (w_hit) begin
                        r_x[gi] <= w_upd_x;
                        if (r_anim_now) begin
                            r_ctrl[gi][0] <= ~r_ctrl[gi][0];
                        end
                    end
                    if (w_wr) begin
                        case (wr_sel)
                            2'b00:   r_x[gi]    <= wr_data;
                            2'b01:   r_y[gi]    <= wr_data;
                            2'b10:   r_ctrl[gi] <= wr_data[3:0];
                            default: r_vel[gi]  <= wr_data[4:0];
                        endcase
                    end
                end
            end

            assign x_flat[gi*11 +: 11]  = r_x[gi];
            assign y_flat[gi*11 +: 11]  = r_y[gi];
            assign ctrl_flat[gi*4 +: 4] = r_ctrl[gi];
        end
    endgenerate

    assign busy    = r_busy;
    assign done    = r_done;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_frog_lane_sched.sv
// Directed bench for frog_lane_sched: hand-computed moves, wraps, animation, collisions,
// overrun, out-of-range writes and mid-scan reset.
module tb_frog_lane_sched;

    localparam int N = 20;

    logic              clk = 1'b0;
    logic              reset;
    logic              frame_tick;
    logic              wr_en;
    logic [4:0]        wr_addr;
    logic [1:0]        wr_sel;
    logic [10:0]       wr_data;
    logic [N*11-1:0]   x_flat;
    logic [N*11-1:0]   y_flat;
    logic [N*4-1:0]    ctrl_flat;
    logic              busy;
    logic              done;
    logic              overrun;

    int n_tests = 0;
    int n_fail  = 0;

    logic [N*11-1:0]   exp_x;
    logic [N*11-1:0]   exp_y;
    logic [N*4-1:0]    exp_c;

    frog_lane_sched dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_sel     (wr_sel),
        .wr_data    (wr_data),
        .x_flat     (x_flat),
        .y_flat     (y_flat),
        .ctrl_flat  (ctrl_flat),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0h", tag, got);
        end
    endtask

    function automatic logic [10:0] x_of(input int i);
        return x_flat[i*11 +: 11];
    endfunction

    function automatic logic [10:0] y_of(input int i);
        return y_flat[i*11 +: 11];
    endfunction

    function automatic logic [3:0] c_of(input int i);
        return ctrl_flat[i*4 +: 4];
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        frame_tick = 1'b0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_sel = '0;
        wr_data = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wr(input int addr, input int sel, input int data);
        wr_en   = 1'b1;
        wr_addr = 5'(addr);
        wr_sel  = 2'(sel);
        wr_data = 11'(data);
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", done, 1'b1);
        @(negedge clk);
    endtask

    task automatic run_frame();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        wait_done();
    endtask

    initial begin
        do_reset();
        check("rst_x", x_flat, '0);
        check("rst_ctrl", ctrl_flat, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_overrun", overrun, 1'b0);

        // Basic move with cycle-accurate timing
        wr(3, 0, 100);
        wr(3, 1, 55);
        wr(3, 3, 4);
        frame_tick = 1'b1;
        @(negedge clk);                 // cycle t+1
        frame_tick = 1'b0;
        check("basic_busy_t1", busy, 1'b1);
        repeat (3) @(negedge clk);      // cycle t+4
        check("basic_x3_t4", x_of(3), 11'd100);
        @(negedge clk);                 // cycle t+5
        check("basic_x3_t5", x_of(3), 11'd104);
        repeat (15) @(negedge clk);     // cycle t+20
        check("basic_done_t20", done, 1'b0);
        @(negedge clk);                 // cycle t+21
        check("basic_done_t21", done, 1'b1);
        check("basic_busy_t21", busy, 1'b1);
        @(negedge clk);                 // cycle t+22
        check("basic_done_t22", done, 1'b0);
        check("basic_busy_t22", busy, 1'b0);
        exp_x = '0;
        exp_x[3*11 +: 11] = 11'd104;
        check("basic_x_all", x_flat, exp_x);
        check("basic_y3", y_of(3), 11'd55);

        // Wrap in both directions
        do_reset();
        wr(0, 0, 670);
        wr(0, 3, 3);
        wr(1, 0, 2);
        wr(1, 3, 5'b11011);
        run_frame();
        check("wrap_x0", x_of(0), 11'd1);
        check("wrap_x1", x_of(1), 11'd669);

        // Animation toggle on every eighth frame
        do_reset();
        wr(0, 2, 4'b1000);
        wr(0, 3, 1);
        wr(2, 0, 77);
        wr(2, 2, 4'b0110);
        for (int k = 1; k <= 8; k++) begin
            run_frame();
            check($sformatf("anim_ctrl0_f%0d", k), c_of(0), (k == 8) ? 4'b1001 : 4'b1000);
            check($sformatf("anim_x0_f%0d", k), x_of(0), 11'(k));
            check($sformatf("anim_ctrl2_f%0d", k), c_of(2), 4'b0110);
        end
        check("anim_x2", x_of(2), 11'd77);

        // CPU write collides with the sweep of slot 5 on an animation frame
        do_reset();
        wr(5, 2, 4'b0100);
        for (int k = 1; k <= 7; k++) run_frame();
        wr(5, 0, 50);
        wr(5, 3, 2);
        frame_tick = 1'b1;
        @(negedge clk);                 // cycle t+1
        frame_tick = 1'b0;
        repeat (5) @(negedge clk);      // cycle t+6, slot 5 sweep cycle
        wr(5, 0, 200);
        wait_done();
        check("coll_x5", x_of(5), 11'd200);
        check("coll_ctrl5", c_of(5), 4'b0101);

        // Second tick during a scan
        do_reset();
        wr(7, 0, 10);
        wr(7, 3, 3);
        frame_tick = 1'b1;
        @(negedge clk);                 // cycle t+1
        frame_tick = 1'b0;
        repeat (4) @(negedge clk);      // cycle t+5
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check("ovr_flag", overrun, 1'b1);
        wait_done();
        check("ovr_x7_once", x_of(7), 11'd13);
        check("ovr_idle", busy, 1'b0);
        run_frame();
        check("ovr_x7_next", x_of(7), 11'd16);
        check("ovr_sticky", overrun, 1'b1);

        // Out-of-range slot address
        wr(25, 0, 999);
        wr(25, 2, 15);
        exp_x = '0;
        exp_x[7*11 +: 11] = 11'd16;
        exp_y = '0;
        exp_c = '0;
        check("oob_x", x_flat, exp_x);
        check("oob_y", y_flat, exp_y);
        check("oob_ctrl", ctrl_flat, exp_c);

        // Reset in the middle of a scan
        wr(4, 1, 40);
        wr(4, 2, 3);
        frame_tick = 1'b1;
        @(negedge clk);                 // cycle t+1
        frame_tick = 1'b0;
        repeat (9) @(negedge clk);      // cycle t+10
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_x", x_flat, '0);
        check("mid_rst_y", y_flat, '0);
        check("mid_rst_ctrl", ctrl_flat, '0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_overrun", overrun, 1'b0);
        reset = 1'b0;
        wr(4, 0, 300);
        wr(4, 3, 1);
        run_frame();
        exp_x = '0;
        exp_x[4*11 +: 11] = 11'd301;
        check("post_rst_x", x_flat, exp_x);
        check("post_rst_ctrl4", c_of(4), 4'b0000);
        check("post_rst_overrun", overrun, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/frog_lane_sched.md
Name: frog_lane_sched

Overview:
- Per-frame motion scheduler for the 20 frog sprite slots. Its outputs feed the x/y origin and 4-bit ctrl inputs of the frog sprite source.
- Holds a position, ctrl word and signed velocity per slot. The CPU writes these registers through a bus port.
- On each frame tick, a sequencer updates one slot per clock. Each update moves x by the slot velocity with horizontal wrap and toggles the animation id every ANIM_DIV frames.

Parameters:
- N_SLOT, 20, number of sprite slots (index width 5 bits).
- SCR_W, 640, visible screen width in pixels.
- H_SIZE, 32, sprite width; wrap span SPAN = SCR_W + H_SIZE = 672.
- ANIM_DIV, 8, frames between animation id toggles (must be >= 1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse, start of frame (vertical blank)
- wr_en  in  1  CPU register write strobe
- wr_addr  in  5  target slot index
- wr_sel  in  2  field select: 00 x, 01 y, 10 ctrl, 11 vel
- wr_data  in  11  write data; ctrl uses [3:0], vel uses [4:0] (signed), x/y use [10:0]
- x_flat  out  N_SLOT*11  slot i x origin at [11i+10:11i]
- y_flat  out  N_SLOT*11  slot i y origin
- ctrl_flat  out  N_SLOT*4  slot i ctrl: [3:2] color_sel, [1:0] id_sel
- busy  out  1  high while the scan is in progress
- done  out  1  one-cycle pulse when a scan completes
- overrun  out  1  sticky; set when frame_tick arrives while busy

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values: all x, y, ctrl and vel = 0; state IDLE; slot index = 0; animation counter = 0; busy = 0, done = 0, overrun = 0. Reset mid-scan aborts the scan immediately, and no partial state is retained.
- FSM states: IDLE, SCAN, FIN.
  - IDLE -> SCAN on frame_tick. The transition sets idx = 0 and latches anim_now = (anim_cnt == ANIM_DIV-1).
  - On the same tick, anim_cnt increments and wraps to 0 after ANIM_DIV-1.
  - SCAN: slot idx is updated each cycle. When idx == N_SLOT-1 the FSM goes to FIN; otherwise idx increments.
  - FIN: done = 1 for one cycle, then IDLE.
- Timing: with frame_tick sampled at cycle t, slot i register update is visible at cycle t+2+i. done is high in cycle t+1+N_SLOT. busy is high in SCAN and FIN (cycles t+1 .. t+1+N_SLOT).
- Slot update rule, with v = signed vel[4:0] (range -16..+15):
  - v = 0: slot unchanged (static; no animation).
  - v > 0: s = x + v; if s >= SPAN then x <= s - SPAN, else x <= s.
  - v < 0: if x < |v| then x <= x + SPAN - |v|, else x <= x - |v|.
  - Arithmetic uses 12-bit unsigned intermediates, so there is no 11-bit overflow.
  - If v != 0 and anim_now is set, ctrl[0] toggles. ctrl[3:1] and y are never modified by the sequencer.
- CPU writes:
  - Accepted in every state, in a single cycle.
  - wr_addr >= N_SLOT is ignored.
  - If the CPU writes the same slot and field the sequencer updates in the same cycle, the CPU value wins and the sequencer result for that field is discarded. Other fields of that slot still take the sequencer result.
- frame_tick while busy is ignored (no restart, no anim_cnt increment) and sets overrun = 1. Only reset clears overrun.
- x values written at or above SPAN are legal. For v > 0, they wrap on the next update (s - SPAN).
- All outputs are registered directly from slot registers; there is no combinational path from inputs to outputs.

Test Plan:
- Basic move: reset; write slot 3 x=100, vel=+4; pulse frame_tick at cycle t.
  - Required: busy rises at t+1, done pulses at t+21, x_flat[3] = 104, all other slots = 0.
- Wrap: slot 0 x=670 vel=+3, slot 1 x=2 vel=-5 (5'b11011); one frame.
  - Required: x0 = 1, x1 = 669.
- Animation with ANIM_DIV=8: slot 0 ctrl=4'b1000 vel=+1; slot 2 ctrl=4'b0110 vel=0; 8 frames.
  - Required: after scans 1–7, ctrl0 = 4'b1000. After scan 8, ctrl0 = 4'b1001 and x0 = 8. Slot 2 is unchanged throughout.
- Collision: slot 5 x=50 vel=+2; write slot 5 x=200 in cycle t+1+5 (the sequencer's slot-5 cycle).
  - Required: x5 = 200 after the scan; ctrl5 is still updated per the rule.
- Overrun and bounds:
  - A second frame_tick at t+5 -> x advances only once and overrun = 1 stays set.
  - A write with wr_addr = 25 -> no register changes.
- Reset mid-scan: assert reset at t+10.
  - Required: next cycle all x/y/ctrl = 0, busy = 0, done = 0, overrun = 0. A following frame_tick starts a clean scan.
